// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage pipeline. Every cycle it
// decides whether PC, IF/ID, ID/EX and EX/MEM load, hold or flush. The
// decision is based on load-use hazards, taken branches, jumps and
// data-memory wait states. It also keeps saturating stall/flush counters and
// a sticky memory-timeout flag.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   ID_rs, ID_rt,       source fields of the instruction in ID
//   ID_UsesRt, ID_Jump
//   EX_MemRead, EX_rt,  load / destination / taken-branch info from EX
//   EX_BranchTaken
//   MEM_Req, MEM_Ready  data-memory request and completion from MEM
//   PC_Wr, IF_ID_Wr,    stage-register write enables and flushes
//   IF_ID_flush, ID_EX_flush, EX_MEM_Wr
//   stall_cnt           saturating count of cycles with PC_Wr=0
//   flush_cnt           saturating count of cycles with any flush
//   mem_timeout         sticky: a memory wait reached MEM_TIMEOUT cycles
//   dbg_state_o         current FSM state (0 = RUN, 1 = MEM_WAIT)
//
// Memory handshake: MEM_Req is the request and MEM_Ready is the completion.
// An access completes on any cycle where both are 1. While MEM_Req=1 and
// MEM_Ready=0 the request must stay asserted, and the whole pipe freezes.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_Wr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic             dbg_state_o
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      WAIT_LIMIT = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic load_use;
  logic mem_stall;
  logic freeze;

  assign load_use  = EX_MemRead & (EX_rt != 5'd0) &
                     ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));
  assign mem_stall = MEM_Req & ~MEM_Ready;
  // Once waiting, only MEM_Ready releases the pipe. This keeps it frozen
  // even if MEM_Req is (illegally) dropped mid-wait.
  assign freeze    = (state_q == ST_MEM_WAIT) ? ~MEM_Ready : mem_stall;

  // State register and all other registered state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mem_stall) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (MEM_Ready) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Output logic. The priority order is: freeze, branch, load-use, jump.
  always_comb begin
    PC_Wr       = 1'b1;
    IF_ID_Wr    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    EX_MEM_Wr   = 1'b1;
    if (!reset) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      EX_MEM_Wr   = 1'b0;
    end else if (freeze) begin
      PC_Wr     = 1'b0;
      IF_ID_Wr  = 1'b0;
      EX_MEM_Wr = 1'b0;
    end else if (EX_BranchTaken) begin
      // Instructions in IF and ID are on the wrong path. Any load-use or
      // jump they carry is therefore irrelevant.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      ID_EX_flush = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_flush = 1'b1;
    end
  end

  // Counters, wait counter and timeout flag.
  always_comb begin
    stall_d   = stall_q;
    flush_d   = flush_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (!PC_Wr && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
    if ((IF_ID_flush | ID_EX_flush) && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_ONE;
    if (state_q == ST_RUN) begin
      if (state_d == ST_MEM_WAIT) wait_d = '0;
    end else begin
      if (wait_q != 16'hFFFF) wait_d = wait_q + 16'd1;
      // wait_d is the number of MEM_WAIT cycles seen in this episode,
      // including the current one.
      if (wait_d == WAIT_LIMIT) timeout_d = 1'b1;
    end
  end

  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign mem_timeout = timeout_q;
  assign dbg_state_o = state_q;

endmodule
